vscale_dmem_responder: RTL and testbench
========================================

# vscale_dmem_responder

Data-memory responder for the vscale core's dmem port: the target that services the pipeline's load/store requests. Accepts the address phase (`dmem_en`/`dmem_wen`/`dmem_size`/`dmem_addr`) issued in DX and completes the data phase in WB, where it returns `dmem_rdata`, `dmem_wait` and `dmem_badmem_e` and consumes `dmem_wdata_delayed`. Contains a word-organised array with byte-lane writes, a programmable wait-state counter and range/alignment checking. Sits beside the pipeline in the top-level / testbench harness, in place of an ideal memory model.

## Interface
Parameters:
- `DEPTH_WORDS`, 1024: array depth in 32-bit words; power of two.
- `BASE_ADDR`, 32'h0000_0000: byte address of word 0; `DEPTH_WORDS*4`-aligned.
- `WAIT_CYCLES`, 0: stall cycles inserted per access; 0..15.

Ports (one clock; reset is asynchronous and active-high):
- `clk` in 1: core clock.
- `reset` in 1: asynchronous, active-high reset.
- `dmem_en` in 1: address-phase request valid.
- `dmem_wen` in 1: 1 = store, 0 = load.
- `dmem_size` in `MEM_TYPE_WIDTH`: 0 byte, 1 half, 2 word, 3 illegal.
- `dmem_addr` in `XPR_LEN`: byte address.
- `dmem_wdata_delayed` in `XPR_LEN`: store data, lane-replicated, valid in data phase.
- `dmem_rdata` out `XPR_LEN`: full aligned word; the core shifts and extends it.
- `dmem_wait` out 1: data phase not yet complete; the core holds DX and WB.
- `dmem_badmem_e` out 1: access error, valid in the final data-phase cycle.

## Operation
- States: IDLE (no data phase pending), WAIT (pending, counter > 0), RESP (final data-phase cycle).
- Address phase is accepted on a rising edge where `dmem_en`=1 and `dmem_wait`=0. Captured: `wen`, `size`, word index, `addr[1:0]` and the error flag. Next state is WAIT if `WAIT_CYCLES`>0, else RESP. The counter loads `WAIT_CYCLES`.
- WAIT: `dmem_wait`=1 and the counter decrements each cycle; at 1, go to RESP. `dmem_en` is ignored here (the core holds the next request stable).
- RESP: `dmem_wait`=0.
  - Load: `dmem_rdata` = array[captured index], read combinationally.
  - Store: lanes commit on the closing edge.
  - If a new request is accepted on that same edge, go to WAIT or RESP for it; otherwise go to IDLE.
- Byte enables:
  - byte: `4'b0001 << addr[1:0]`
  - half: `4'b0011 << {addr[1],1'b0}`
  - word: `4'hF`
  - Lane i writes `dmem_wdata_delayed[8i+7:8i]`.
- Error when any of the following holds:
  - `dmem_addr-BASE_ADDR >= DEPTH_WORDS*4` (unsigned, 32-bit wrap);
  - half with `addr[0]`=1;
  - word with `addr[1:0]`≠0;
  - size 3.
  
  On error: `dmem_badmem_e`=1 in RESP, the store is suppressed and `dmem_rdata`=0.
- `dmem_rdata`=0 and `dmem_badmem_e`=0 outside RESP, and during a store RESP.
- Reset (asynchronous, any state):
  - state IDLE, counter 0;
  - `dmem_wait`=0, `dmem_badmem_e`=0, `dmem_rdata`=0;
  - a pending store is dropped; array contents are not reset.

## Timing
- Zero wait: request at edge N, RESP in cycle N..N+1, store committed at edge N+1. Back-to-back accesses run at one per cycle.
- With `WAIT_CYCLES`=W: `dmem_wait` is high for exactly W cycles after acceptance, then one RESP cycle. Access latency is W+1 cycles.
- A load whose RESP follows a store's RESP to the same word returns the stored data; no forwarding path is needed because the read happens after the commit edge.
- `dmem_wait`, `dmem_badmem_e` and `dmem_rdata` are decoded from registered state plus the array. The only combinational input-to-output path is none; request inputs only affect state at the next edge.

## Structure
- `MEM_TYPE_WIDTH`, the size encodings and `XPR_LEN` come from the shared `vscale_ctrl_constants.vh` / `vscale_platform_constants.vh`; no new constants are added there.
- State encoding is a local `localparam`.
- One sub-module, `vscale_dmem_lane_wr`: combinational byte-enable and error decode from {size, addr[1:0], range-hit}. It is reused by a future imem responder.

## Test plan
- Zero wait, SW 0xDEADBEEF @0x10 then LW @0x10 back-to-back -> `dmem_wait` never high; the LW RESP returns 0xDEADBEEF.
- SB 0x000000AA (replicated 0xAAAAAAAA) @0x13 over word 0x11223344 -> LW returns 0xAA223344; SH 0xBBBB @0x12 -> 0xBBBB3344.
- `WAIT_CYCLES`=3, LW @0x20 held on `dmem_en` -> `dmem_wait` high for exactly 3 cycles, data valid in the 4th, next request accepted on that closing edge.
- LW @0x2 (misaligned), SH @0x5 and SW @`DEPTH_WORDS*4` -> `dmem_badmem_e`=1 in RESP, `dmem_rdata`=0, the array is unchanged (verified by a follow-up LW).
- `WAIT_CYCLES`=2, assert `reset` asynchronously mid-WAIT of a SW -> outputs 0 immediately, state IDLE, the store is not committed.
- Size 3 request -> `dmem_badmem_e`=1; an idle cycle (`dmem_en`=0) -> all outputs 0.

Source files
------------

// File: rtl/vscale_dmem_responder_pkg.sv
// Shared constants and payload types for the vscale data-memory responder.
//   XPR_LEN         : data/address width of the core.
//   MEM_TYPE_WIDTH  : width of dmem_size (access size encoding).
//   MEM_TYPE_*      : byte / half / word size encodings; anything else is illegal.
package vscale_dmem_responder_pkg;

    localparam int unsigned XPR_LEN        = 32;
    localparam int unsigned MEM_TYPE_WIDTH = 3;
    localparam int unsigned NUM_LANES      = XPR_LEN / 8;
    localparam int unsigned WAIT_CNT_W     = 4;

    localparam logic [MEM_TYPE_WIDTH-1:0] MEM_TYPE_B = MEM_TYPE_WIDTH'(0);
    localparam logic [MEM_TYPE_WIDTH-1:0] MEM_TYPE_H = MEM_TYPE_WIDTH'(1);
    localparam logic [MEM_TYPE_WIDTH-1:0] MEM_TYPE_W = MEM_TYPE_WIDTH'(2);

    // Request attributes captured at the address phase and used in the data phase.
    typedef struct packed {
        logic                 wen;
        logic [NUM_LANES-1:0] be;
        logic                 err;
    } dmem_req_t;

endpackage

// File: rtl/vscale_dmem_lane_wr.sv
// Combinational byte-enable and access-error decode for a 32-bit word memory.
//   mem_size_i  : access size (byte / half / word / illegal).
//   byte_off_i  : address bits [1:0].
//   range_hit_i : address lies inside the array.
//   byte_en_c_o : lane write enables.
//   err_c_o     : out of range, misaligned, or illegal size.
module vscale_dmem_lane_wr
    import vscale_dmem_responder_pkg::*;
(
    input  logic [MEM_TYPE_WIDTH-1:0] mem_size_i,
    input  logic [1:0]                byte_off_i,
    input  logic                      range_hit_i,
    output logic [NUM_LANES-1:0]      byte_en_c_o,
    output logic                      err_c_o
);

    // Lane selection plus alignment check per access size.
    always_comb begin
        byte_en_c_o = '0;
        err_c_o     = !range_hit_i;
        case (mem_size_i)
            MEM_TYPE_B: begin
                byte_en_c_o = 4'b0001 << byte_off_i;
            end
            MEM_TYPE_H: begin
                byte_en_c_o = 4'b0011 << {byte_off_i[1], 1'b0};
                if (byte_off_i[0]) err_c_o = 1'b1;
            end
            MEM_TYPE_W: begin
                byte_en_c_o = 4'hF;
                if (byte_off_i != 2'b00) err_c_o = 1'b1;
            end
            default: begin
                err_c_o = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/vscale_dmem_responder.sv
// Data-memory responder for the vscale dmem port. Accepts the address phase
// in DX, optionally stalls WAIT_CYCLES cycles, then completes the data phase
// in a single response cycle (load data / store commit / error).
//   clk, reset          : core clock, asynchronous active-high reset.
//   dmem_en/wen/size/addr : address-phase request.
//   dmem_wdata_delayed  : lane-replicated store data, valid in the data phase.
//   dmem_rdata          : full aligned word during a load response, else 0.
//   dmem_wait           : data phase still pending; core holds DX and WB.
//   dmem_badmem_e       : access error, asserted in the response cycle.
module vscale_dmem_responder
    import vscale_dmem_responder_pkg::*;
#(
    parameter int unsigned  DEPTH_WORDS = 1024,
    parameter logic [31:0]  BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned  WAIT_CYCLES = 0
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      dmem_en,
    input  logic                      dmem_wen,
    input  logic [MEM_TYPE_WIDTH-1:0] dmem_size,
    input  logic [XPR_LEN-1:0]        dmem_addr,
    input  logic [XPR_LEN-1:0]        dmem_wdata_delayed,
    output logic [XPR_LEN-1:0]        dmem_rdata,
    output logic                      dmem_wait,
    output logic                      dmem_badmem_e
);

    localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    state_e                  state_q, state_d;
    logic [WAIT_CNT_W-1:0]   cnt_q, cnt_d;
    dmem_req_t               req_q, req_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [XPR_LEN-1:0]      mem_q [DEPTH_WORDS];

    logic [XPR_LEN-1:0]      offset_c;
    logic                    range_hit_c;
    logic                    accept_c;
    logic                    commit_c;
    logic [NUM_LANES-1:0]    be_c;
    logic                    err_c;

    // Offset from the array base; wraps below BASE_ADDR so it lands out of range.
    assign offset_c    = dmem_addr - BASE_ADDR;
    assign range_hit_c = offset_c[XPR_LEN-1:2] < (XPR_LEN-2)'(DEPTH_WORDS);
    assign accept_c    = dmem_en && (state_q != ST_WAIT);

    vscale_dmem_lane_wr u_lane_wr (
        .mem_size_i  (dmem_size),
        .byte_off_i  (offset_c[1:0]),
        .range_hit_i (range_hit_c),
        .byte_en_c_o (be_c),
        .err_c_o     (err_c)
    );

    // State and captured-request registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            req_q   <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            idx_q   <= idx_d;
        end
    end

    // Next-state: count down stalls, close the data phase, accept the next request.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        req_d   = req_q;
        idx_d   = idx_q;
        case (state_q)
            ST_WAIT: begin
                cnt_d = cnt_q - WAIT_CNT_W'(1);
                if (cnt_q <= WAIT_CNT_W'(1)) state_d = ST_RESP;
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        // Only reachable from IDLE or RESP, so it overrides the transitions above.
        if (accept_c) begin
            state_d   = (WAIT_CYCLES > 0) ? ST_WAIT : ST_RESP;
            cnt_d     = WAIT_CNT_W'(WAIT_CYCLES);
            req_d.wen = dmem_wen;
            req_d.be  = be_c;
            req_d.err = err_c;
            idx_d     = offset_c[IDX_W+1:2];
        end
    end

    // Outputs are decoded from registered state and the array only.
    always_comb begin
        dmem_wait     = (state_q == ST_WAIT);
        dmem_badmem_e = (state_q == ST_RESP) && req_q.err;
        dmem_rdata    = '0;
        if ((state_q == ST_RESP) && !req_q.wen && !req_q.err) begin
            dmem_rdata = mem_q[idx_q];
        end
    end

    assign commit_c = (state_q == ST_RESP) && req_q.wen && !req_q.err;

    // Store commit on the closing edge of the response cycle; array is not reset.
    always_ff @(posedge clk) begin
        if (commit_c) begin
            for (int i = 0; i < int'(NUM_LANES); i++) begin
                if (req_q.be[i]) mem_q[idx_q][8*i +: 8] <= dmem_wdata_delayed[8*i +: 8];
            end
        end
    end

endmodule

// File: tb/tb_vscale_dmem_responder.sv
module tb_vscale_dmem_responder;

    logic             clk;
    logic             reset;
    logic [2:0]       en;
    logic [2:0]       wen;
    logic [2:0][2:0]  size;
    logic [2:0][31:0] addr;
    logic [2:0][31:0] wd;
    logic [2:0][31:0] rd;
    logic [2:0]       wt;
    logic [2:0]       bad;

    int checks;
    int errors;

    localparam logic [2:0] SZ_B = 3'd0;
    localparam logic [2:0] SZ_H = 3'd1;
    localparam logic [2:0] SZ_W = 3'd2;
    localparam logic [2:0] SZ_X = 3'd3;

    vscale_dmem_responder #(.WAIT_CYCLES(0)) u_dut0 (
        .clk(clk), .reset(reset), .dmem_en(en[0]), .dmem_wen(wen[0]), .dmem_size(size[0]),
        .dmem_addr(addr[0]), .dmem_wdata_delayed(wd[0]), .dmem_rdata(rd[0]),
        .dmem_wait(wt[0]), .dmem_badmem_e(bad[0]));

    vscale_dmem_responder #(.WAIT_CYCLES(3)) u_dut3 (
        .clk(clk), .reset(reset), .dmem_en(en[1]), .dmem_wen(wen[1]), .dmem_size(size[1]),
        .dmem_addr(addr[1]), .dmem_wdata_delayed(wd[1]), .dmem_rdata(rd[1]),
        .dmem_wait(wt[1]), .dmem_badmem_e(bad[1]));

    vscale_dmem_responder #(.WAIT_CYCLES(2)) u_dut2 (
        .clk(clk), .reset(reset), .dmem_en(en[2]), .dmem_wen(wen[2]), .dmem_size(size[2]),
        .dmem_addr(addr[2]), .dmem_wdata_delayed(wd[2]), .dmem_rdata(rd[2]),
        .dmem_wait(wt[2]), .dmem_badmem_e(bad[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One complete access on channel k, starting and ending at a falling edge.
    task automatic single_access(input int k, input logic w, input logic [2:0] sz,
                                 input logic [31:0] a, input logic [31:0] d,
                                 output logic [31:0] rdo, output logic bo, output int waits);
        en[k] = 1'b1; wen[k] = w; size[k] = sz; addr[k] = a; wd[k] = d;
        @(negedge clk);
        en[k] = 1'b0;
        waits = 0;
        while (wt[k] && waits < 32) begin
            waits++;
            @(negedge clk);
        end
        rdo = rd[k];
        bo  = bad[k];
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        en = '0; wen = '0; size = '0; addr = '0; wd = '0;
        @(negedge clk);
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (rd[k] !== 32'h0 || wt[k] !== 1'b0 || bad[k] !== 1'b0) begin
                errors++;
                $display("FAIL reset_outputs dut%0d: rdata=%h wait=%b bad=%b expected 0/0/0", k, rd[k], wt[k], bad[k]);
            end
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_zero_wait_b2b();
        int seen_wait;
        seen_wait = 0;
        en[0] = 1'b1; wen[0] = 1'b1; size[0] = SZ_W; addr[0] = 32'h10; wd[0] = 32'hDEADBEEF;
        @(negedge clk);
        if (wt[0]) seen_wait++;
        checks++;
        if (rd[0] !== 32'h0 || bad[0] !== 1'b0) begin
            errors++;
            $display("FAIL sw_resp: rdata=%h bad=%b expected 00000000/0", rd[0], bad[0]);
        end
        wen[0] = 1'b0; addr[0] = 32'h10;
        @(negedge clk);
        if (wt[0]) seen_wait++;
        checks++;
        if (rd[0] !== 32'hDEADBEEF || bad[0] !== 1'b0) begin
            errors++;
            $display("FAIL b2b_lw: rdata=%h bad=%b expected deadbeef/0", rd[0], bad[0]);
        end
        en[0] = 1'b0;
        @(negedge clk);
        checks++;
        if (seen_wait != 0) begin
            errors++;
            $display("FAIL zero_wait_stall: wait cycles=%0d expected 0", seen_wait);
        end
        checks++;
        if (rd[0] !== 32'h0 || wt[0] !== 1'b0 || bad[0] !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_b2b: rdata=%h wait=%b bad=%b expected 0/0/0", rd[0], wt[0], bad[0]);
        end
    endtask

    task automatic test_byte_lanes();
        logic [31:0] r; logic b; int n;
        logic [2:0]  szs  [5] = '{SZ_W,         SZ_B,         SZ_H,         SZ_B,         SZ_H};
        logic [31:0] adrs [5] = '{32'h30,       32'h33,       32'h32,       32'h30,       32'h30};
        logic [31:0] dats [5] = '{32'h11223344, 32'hAAAAAAAA, 32'hBBBBBBBB, 32'hCCCCCCCC, 32'h55555555};
        logic [31:0] exps [5] = '{32'h11223344, 32'hAA223344, 32'hBBBB3344, 32'hBBBB33CC, 32'hBBBB5555};
        for (int i = 0; i < 5; i++) begin
            single_access(0, 1'b1, szs[i], adrs[i], dats[i], r, b, n);
            single_access(0, 1'b0, SZ_W, 32'h30, 32'h0, r, b, n);
            checks++;
            if (r !== exps[i] || b !== 1'b0) begin
                errors++;
                $display("FAIL lane_store_%0d: rdata=%h bad=%b expected %h/0", i, r, b, exps[i]);
            end
        end
        // Byte load returns the whole aligned word.
        single_access(0, 1'b0, SZ_B, 32'h31, 32'h0, r, b, n);
        checks++;
        if (r !== 32'hBBBB5555 || b !== 1'b0) begin
            errors++;
            $display("FAIL lb_full_word: rdata=%h bad=%b expected bbbb5555/0", r, b);
        end
    endtask

    task automatic test_wait_states();
        logic [31:0] r; logic b; int n;
        single_access(1, 1'b1, SZ_W, 32'h20, 32'h12345678, r, b, n);
        checks++;
        if (n != 3) begin
            errors++;
            $display("FAIL sw_wait_count: wait cycles=%0d expected 3", n);
        end
        en[1] = 1'b1; wen[1] = 1'b0; size[1] = SZ_W; addr[1] = 32'h20;
        @(negedge clk);
        n = 0;
        while (wt[1] && n < 32) begin
            n++;
            @(negedge clk);
        end
        checks++;
        if (n != 3) begin
            errors++;
            $display("FAIL lw_wait_count: wait cycles=%0d expected 3", n);
        end
        checks++;
        if (rd[1] !== 32'h12345678 || bad[1] !== 1'b0) begin
            errors++;
            $display("FAIL lw_wait_data: rdata=%h bad=%b expected 12345678/0", rd[1], bad[1]);
        end
        addr[1] = 32'h24;
        @(negedge clk);
        checks++;
        if (wt[1] !== 1'b1) begin
            errors++;
            $display("FAIL accept_on_resp_edge: wait=%b expected 1", wt[1]);
        end
        en[1] = 1'b0;
        n = 0;
        while (wt[1] && n < 32) begin
            n++;
            @(negedge clk);
        end
        @(negedge clk);
    endtask

    task automatic test_errors();
        logic [31:0] r; logic b; int n;
        single_access(0, 1'b1, SZ_W, 32'h0, 32'h11111111, r, b, n);
        single_access(0, 1'b1, SZ_W, 32'h4, 32'h22222222, r, b, n);
        checks++;
        if (b !== 1'b0) begin
            errors++;
            $display("FAIL good_sw_bad: bad=%b expected 0", b);
        end
        single_access(0, 1'b0, SZ_W, 32'h2, 32'h0, r, b, n);
        checks++;
        if (b !== 1'b1 || r !== 32'h0) begin
            errors++;
            $display("FAIL lw_misaligned: rdata=%h bad=%b expected 00000000/1", r, b);
        end
        single_access(0, 1'b1, SZ_H, 32'h5, 32'hFFFFFFFF, r, b, n);
        checks++;
        if (b !== 1'b1 || r !== 32'h0) begin
            errors++;
            $display("FAIL sh_misaligned: rdata=%h bad=%b expected 00000000/1", r, b);
        end
        single_access(0, 1'b1, SZ_W, 32'h1000, 32'h99999999, r, b, n);
        checks++;
        if (b !== 1'b1 || r !== 32'h0) begin
            errors++;
            $display("FAIL sw_out_of_range: rdata=%h bad=%b expected 00000000/1", r, b);
        end
        single_access(0, 1'b0, SZ_W, 32'h4, 32'h0, r, b, n);
        checks++;
        if (r !== 32'h22222222 || b !== 1'b0) begin
            errors++;
            $display("FAIL word1_unchanged: rdata=%h bad=%b expected 22222222/0", r, b);
        end
        single_access(0, 1'b0, SZ_W, 32'h0, 32'h0, r, b, n);
        checks++;
        if (r !== 32'h11111111 || b !== 1'b0) begin
            errors++;
            $display("FAIL word0_unchanged: rdata=%h bad=%b expected 11111111/0", r, b);
        end
        single_access(0, 1'b0, SZ_W, 32'hFFC, 32'h0, r, b, n);
        checks++;
        if (b !== 1'b0) begin
            errors++;
            $display("FAIL last_word_in_range: bad=%b expected 0", b);
        end
    endtask

    task automatic test_size3_idle();
        logic [31:0] r; logic b; int n;
        single_access(0, 1'b0, SZ_X, 32'h0, 32'h0, r, b, n);
        checks++;
        if (b !== 1'b1 || r !== 32'h0) begin
            errors++;
            $display("FAIL size3: rdata=%h bad=%b expected 00000000/1", r, b);
        end
        en[0] = 1'b0;
        @(negedge clk);
        checks++;
        if (rd[0] !== 32'h0 || wt[0] !== 1'b0 || bad[0] !== 1'b0) begin
            errors++;
            $display("FAIL idle_outputs: rdata=%h wait=%b bad=%b expected 0/0/0", rd[0], wt[0], bad[0]);
        end
    endtask

    task automatic test_async_reset();
        logic [31:0] r; logic b; int n;
        single_access(2, 1'b1, SZ_W, 32'h50, 32'hCAFEF00D, r, b, n);
        checks++;
        if (n != 2) begin
            errors++;
            $display("FAIL w2_sw_wait_count: wait cycles=%0d expected 2", n);
        end
        en[2] = 1'b1; wen[2] = 1'b1; size[2] = SZ_W; addr[2] = 32'h50; wd[2] = 32'h0BADF00D;
        @(negedge clk);
        en[2] = 1'b0;
        checks++;
        if (wt[2] !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_wait: wait=%b expected 1", wt[2]);
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if (rd[2] !== 32'h0 || wt[2] !== 1'b0 || bad[2] !== 1'b0) begin
            errors++;
            $display("FAIL async_reset_outputs: rdata=%h wait=%b bad=%b expected 0/0/0", rd[2], wt[2], bad[2]);
        end
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (rd[2] !== 32'h0 || wt[2] !== 1'b0 || bad[2] !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_idle: rdata=%h wait=%b bad=%b expected 0/0/0", rd[2], wt[2], bad[2]);
        end
        single_access(2, 1'b0, SZ_W, 32'h50, 32'h0, r, b, n);
        checks++;
        if (r !== 32'hCAFEF00D || b !== 1'b0 || n != 2) begin
            errors++;
            $display("FAIL store_dropped: rdata=%h bad=%b waits=%0d expected cafef00d/0/2", r, b, n);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_zero_wait_b2b();
        test_byte_lanes();
        test_wait_states();
        test_errors();
        test_size3_idle();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
